// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage: special instruction words,
// fetch FSM state encoding and the sequential PC increment.
package fetch_pkg;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP   = 32'd4;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: holds on stall, loads a NOP bubble on flush,
// otherwise captures a valid instruction and its PC+4.
module if_id_register
    import fetch_pkg::*;
#(
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic         bubble,
    input  logic [B-1:0] instr_d,
    input  logic [B-1:0] pc_plus4_d,
    output logic [B-1:0] instr,
    output logic [B-1:0] pc_plus4,
    output logic         valid
);

    logic [B-1:0] instr_q;
    logic [B-1:0] pc_plus4_q;
    logic         valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q    <= B'(NOP_WORD);
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (hold) begin
            instr_q    <= instr_q;
            pc_plus4_q <= pc_plus4_q;
            valid_q    <= valid_q;
        end else if (bubble) begin
            instr_q    <= B'(NOP_WORD);
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= 1'b1;
        end
    end

    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC selection, run/halt FSM and fetch counter,
// feeding the IF/ID register that drives decode.
//   state      | meaning
//   ST_RUN     | fetching; stall > jump > branch > flush > normal
//   ST_HALTED  | HALT word latched; PC and counter frozen, IF/ID drains to bubbles
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int           B        = 32,
    parameter int           W        = 8,
    parameter logic [B-1:0] PC_RESET = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic         branch_taken,
    input  logic [B-1:0] branch_target,
    input  logic         jump_taken,
    input  logic [B-1:0] jump_target,
    output logic [W-1:0] imem_addr,
    input  logic [B-1:0] imem_data,
    output logic [B-1:0] if_id_instr,
    output logic [B-1:0] if_id_pc_plus4,
    output logic         if_id_valid,
    output logic         halted,
    output logic [31:0]  fetch_count
);

    localparam logic [B-1:0] ALIGN_MASK = {{(B-2){1'b1}}, 2'b00};

    logic [0:0]   state_q, state_d;
    logic [B-1:0] pc_q, pc_d;
    logic [31:0]  count_q, count_d;
    logic [B-1:0] pc_plus4;
    logic         ifid_hold;
    logic         ifid_bubble;

    assign pc_plus4  = pc_q + B'(PC_STEP);
    assign imem_addr = pc_q[W+1:2];

    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        count_d     = count_q;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
        if (stall) begin
            ifid_hold = 1'b1;
        end else if (state_q == ST_HALTED) begin
            ifid_bubble = 1'b1;
        end else if (jump_taken) begin
            pc_d        = jump_target & ALIGN_MASK;
            ifid_bubble = 1'b1;
        end else if (branch_taken) begin
            pc_d        = branch_target & ALIGN_MASK;
            ifid_bubble = 1'b1;
        end else if (flush) begin
            pc_d        = pc_plus4;
            ifid_bubble = 1'b1;
        end else begin
            pc_d    = pc_plus4;
            count_d = count_q + 32'd1;
            // Only a HALT word that actually lands in IF/ID as valid stops fetch
            if (imem_data == B'(HALT_WORD)) begin
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= PC_RESET;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_register #(.B(B)) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .hold       (ifid_hold),
        .bubble     (ifid_bubble),
        .instr_d    (imem_data),
        .pc_plus4_d (pc_plus4),
        .instr      (if_id_instr),
        .pc_plus4   (if_id_pc_plus4),
        .valid      (if_id_valid)
    );

    assign halted      = (state_q == ST_HALTED);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed cycles push hand-computed
// post-edge expectations; a monitor pops and compares after each rising edge.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, branch_taken, jump_taken;
    logic [31:0] branch_target, jump_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr, if_id_pc_plus4, fetch_count;
    logic        if_id_valid, halted;

    logic [31:0] mem [256];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halt;
        logic [31:0] cnt;
        logic [7:0]  addr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instruction_fetch #(.B(32), .W(8), .PC_RESET(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump_taken     (jump_taken),
        .jump_target    (jump_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " imem_addr"}, {24'h0, imem_addr}, 32'h0);
        chk({tag, " instr"}, if_id_instr, 32'h0);
        chk({tag, " pc_plus4"}, if_id_pc_plus4, 32'h0);
        chk({tag, " valid"}, {31'h0, if_id_valid}, 32'h0);
        chk({tag, " halted"}, {31'h0, halted}, 32'h0);
        chk({tag, " count"}, fetch_count, 32'h0);
    endtask

    // Called at a falling edge: drive inputs, queue the state expected after
    // the next rising edge, then advance to the following falling edge.
    task automatic cyc(input logic st, input logic fl,
                       input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt,
                       input logic [31:0] ei, input logic [31:0] ep, input logic ev,
                       input logic eh, input logic [31:0] ec, input logic [7:0] ea);
        exp_t e;
        stall = st; flush = fl;
        branch_taken = br; branch_target = bt;
        jump_taken = jp; jump_target = jt;
        e.instr = ei; e.pc4 = ep; e.valid = ev; e.halt = eh; e.cnt = ec; e.addr = ea;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic norm(input logic [31:0] ei, input logic [31:0] ep, input logic eh,
                        input logic [31:0] ec, input logic [7:0] ea);
        cyc(0, 0, 0, 0, 0, 0, ei, ep, 1'b1, eh, ec, ea);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("instr", if_id_instr, e.instr);
                chk("pc_plus4", if_id_pc_plus4, e.pc4);
                chk("valid", {31'h0, if_id_valid}, {31'h0, e.valid});
                chk("halted", {31'h0, halted}, {31'h0, e.halt});
                chk("fetch_count", fetch_count, e.cnt);
                chk("imem_addr", {24'h0, imem_addr}, {24'h0, e.addr});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h2001_0001;
        mem[1] = 32'h2002_0002;
        mem[2] = 32'h2003_0003;
        mem[3] = 32'h2004_0004;
        reset = 1'b0;
        stall = 0; flush = 0; branch_taken = 0; jump_taken = 0;
        branch_target = 0; jump_target = 0;
        #1;
        chk_reset("por");
        @(negedge clk);
        reset = 1'b1;

        // sequential fetch of words 0..4
        norm(32'h2001_0001, 32'd4,  0, 1, 8'd1);
        norm(32'h2002_0002, 32'd8,  0, 2, 8'd2);
        norm(32'h2003_0003, 32'd12, 0, 3, 8'd3);
        norm(32'h2004_0004, 32'd16, 0, 4, 8'd4);
        norm(32'h1000_0004, 32'd20, 0, 5, 8'd5);

        // asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        reset = 1'b1;

        norm(32'h2001_0001, 32'd4, 0, 1, 8'd1);
        // stall three cycles; a branch request during stall is ignored
        cyc(1, 0, 0, 0,            0, 0, 32'h2001_0001, 32'd4, 1, 0, 1, 8'd1);
        cyc(1, 1, 1, 32'h0000_0040, 0, 0, 32'h2001_0001, 32'd4, 1, 0, 1, 8'd1);
        cyc(1, 0, 0, 0,            0, 0, 32'h2001_0001, 32'd4, 1, 0, 1, 8'd1);
        norm(32'h2002_0002, 32'd8, 0, 2, 8'd2);

        // jump beats branch in the same cycle
        cyc(0, 0, 1, 32'h0000_0040, 1, 32'h0000_0080, 32'h0, 32'h0, 0, 0, 2, 8'h20);
        norm(32'h1000_0020, 32'h84, 0, 3, 8'h21);
        // misaligned branch target
        cyc(0, 0, 1, 32'h0000_0043, 0, 0, 32'h0, 32'h0, 0, 0, 3, 8'h10);
        norm(32'h1000_0010, 32'h44, 0, 4, 8'h11);
        // flush advances PC but discards the word
        cyc(0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 4, 8'h12);
        norm(32'h1000_0012, 32'h4C, 0, 5, 8'h13);
        // PC wrap from 0xFFFF_FFFC
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 5, 8'hFF);
        norm(32'h1000_00FF, 32'h0, 0, 6, 8'h00);
        norm(32'h2001_0001, 32'd4, 0, 7, 8'h01);

        // HALT at byte address 0x10
        mem[4] = 32'hFFFF_FFFF;
        #2;
        reset = 1'b0;
        #1;
        chk_reset("rst2");
        @(negedge clk);
        reset = 1'b1;
        norm(32'h2001_0001, 32'd4,  0, 1, 8'd1);
        norm(32'h2002_0002, 32'd8,  0, 2, 8'd2);
        norm(32'h2003_0003, 32'd12, 0, 3, 8'd3);
        norm(32'h2004_0004, 32'd16, 0, 4, 8'd4);
        norm(32'hFFFF_FFFF, 32'h14, 1, 5, 8'd5);
        cyc(0, 0, 0, 0, 0, 0,             32'h0, 32'h0, 0, 1, 5, 8'd5);
        cyc(0, 0, 0, 0, 1, 32'h0000_0080, 32'h0, 32'h0, 0, 1, 5, 8'd5);
        cyc(1, 0, 0, 0, 0, 0,             32'h0, 32'h0, 0, 1, 5, 8'd5);
        cyc(0, 1, 1, 32'h0000_0040, 0, 0, 32'h0, 32'h0, 0, 1, 5, 8'd5);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
